// File: rtl/addsub_issuer.sv
// Requester-side front end for the registered add/subtract unit.
// One request in flight; response carries carry/borrow and a self-check flag.
module addsub_issuer #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter bit CHK_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_mismatch,
  output logic [WIDTH-1:0] dataa,
  output logic [WIDTH-1:0] datab,
  output logic             add_sub,
  input  logic [WIDTH-1:0] result,
  output logic [15:0]      err_cnt
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  ref_q;
  logic            accept;
  logic            capture;
  logic            done;
  logic            mm;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);
  assign capture   = (state == WAIT) && (cnt == '0);
  assign done      = (state == RESP) && rsp_ready;
  assign mm        = CHK_EN && (result != ref_q[WIDTH-1:0]);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)  state_nx = WAIT;
      WAIT:    if (capture) state_nx = RESP;
      RESP:    if (done)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Reference is computed one bit wider so bit WIDTH is carry (add) or borrow (sub).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataa        <= '0;
      datab        <= '0;
      add_sub      <= 1'b0;
      ref_q        <= '0;
      cnt          <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (accept) begin
        dataa   <= req_a;
        datab   <= req_b;
        add_sub <= req_op;
        ref_q   <= req_op ? ({1'b0, req_a} + {1'b0, req_b})
                          : ({1'b0, req_a} - {1'b0, req_b});
        cnt     <= CW'(LATENCY);
      end
      if ((state == WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;
      if (capture) begin
        rsp_result   <= result;
        rsp_carry    <= ref_q[WIDTH];
        rsp_mismatch <= mm;
        if (mm && (err_cnt != 16'hFFFF))
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
